threshold_mac_seq: RTL
======================

// Module: threshold_mac_seq
// PURPOSE
//   Sequential weighted-sum front end for the threshold logic gate stage.
//   - Accepts N_INPUTS (x, w) pairs serially over a valid/ready stream.
//   - Accumulates the signed sum of x*w for the group.
//   - Compares the sum against a per-group threshold and emits a one-bit fire decision F
//     plus the raw sum, so that downstream threshold/decision logic consumes a single result.
// PARAMETERS
//   DATA_W    16  width of x and w (signed two's complement)
//   N_INPUTS  4   pairs per group (>=1)
//   CNT_W     $clog2(N_INPUTS+1)  beat counter width (derived)
//   ACC_W     2*DATA_W+CNT_W  accumulator/threshold width (derived; no overflow possible)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clr        in   1       synchronous abort; drops the current group
//   in_valid   in   1       x/w/th valid
//   in_ready   out  1       block can accept a pair
//   x          in   DATA_W  signed input value
//   w          in   DATA_W  signed weight
//   th         in   ACC_W   signed threshold; sampled only on the first beat of a group
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts result
//   F          out  1       1 when sum >= threshold (signed compare)
//   sum        out  ACC_W   signed accumulated sum of the group
//   beat_cnt   out  CNT_W   pairs accepted so far in the current group
// BEHAVIOUR
//   One clock domain: clk. Reset is asynchronous, active-low (rst_n).
//   Reset (rst_n=0, async):
//     - state=IDLE, acc=0, th_q=0, beat_cnt=0.
//     - out_valid=0, F=0, sum=0.
//     - in_ready=0 while rst_n=0; in_ready=1 in the first cycle after release.
//   Handshakes:
//     - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//     - in_ready = (state!=DONE) && !clr (combinational).
//     - out_valid = (state==DONE), registered.
//   States:
//     IDLE:  no group open, acc=0.
//       - On transfer: acc<=sext(x*w); th_q<=th; beat_cnt<=1.
//       - Go to ACCUM, or straight to DONE when N_INPUTS==1.
//     ACCUM: on transfer, acc<=acc+sext(x*w) and beat_cnt++.
//       - The Nth transfer goes to DONE.
//       - No transfer: hold all state.
//     DONE:  sum<=final acc and F<=(final acc >= th_q) are registered on the Nth-beat edge.
//       - Both are held stable while out_valid=1 && !out_ready.
//       - On output transfer: go to IDLE; acc and beat_cnt cleared.
//       - in_ready is still 0 in that cycle.
//   Latency:
//     - out_valid rises in the cycle after the Nth input transfer.
//     - Minimum group period = N_INPUTS+1 cycles when out_ready is tied high.
//   Arithmetic:
//     - Full-precision signed product of width 2*DATA_W, sign-extended to ACC_W.
//     - No saturation and no wrap possible at the derived ACC_W.
//   Boundary conditions:
//     - th is ignored on all beats after the first; a change mid-group has no effect.
//     - clr=1 in any state: next state IDLE, acc=0, beat_cnt=0, out_valid=0.
//       clr has priority over both handshakes; an unconsumed result is discarded.
//     - in_valid while in DONE: stalled (in_ready=0); upstream must hold its data.
//     - rst_n asserted mid-group or in DONE: immediate async return to reset values.
//       No partial result is ever presented.
//     - sum==th_q exactly: F=1.
// TESTING
//   1. N=4; x={1,0,1,1}, w={1,1,1,1}, th=3 -> sum=3, F=1; out_valid rises exactly 1 cycle after the 4th beat.
//   2. Same stream, th=4 -> sum=3, F=0. Then x={-2,3,0,0}, w={5,-1,7,7}, th=-14 -> sum=-13, F=1.
//   3. Extremes: x=w=-32768 on all 4 beats, th=0 -> sum=2^32, F=1; no overflow.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> in_ready=0; sum and F stable; group 2 starts only after output transfer.
//   5. Abort: clr at beat 2 of 4, then a fresh group x={1,1,1,1}, w={2,2,2,2}, th=8 -> sum=8, F=1; aborted beats not included.
//   6. Async reset: drop rst_n mid-ACCUM between clock edges -> outputs zero immediately; in_ready=1 on the first cycle after release.
//   7. Randomized: random in_valid/out_ready gaps against a reference model -> every group matches and none is dropped or duplicated.

Source files
------------

// File: rtl/threshold_mac_seq.sv
// threshold_mac_seq: serial signed multiply-accumulate over N_INPUTS (x, w) beats,
// then a signed compare of the group sum against the threshold captured on beat 1.
// A single registered result (sum, F) is presented on a valid/ready output.
module threshold_mac_seq #(
  parameter int DATA_W   = 16,
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = $clog2(N_INPUTS + 1),
  parameter int ACC_W    = 2 * DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  input  logic [ACC_W-1:0]  th,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              F,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ACC_W-1:0]        acc, th_q;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]        prod_ext, acc_base, acc_sum, th_eff;
  logic                    last_beat, fire, in_xfer, out_xfer;

  // Full-precision product, sign-extended; ACC_W leaves CNT_W guard bits so N beats never wrap.
  assign prod     = $signed(x) * $signed(w);
  assign prod_ext = {{CNT_W{prod[2*DATA_W-1]}}, prod};
  assign acc_base = (state == IDLE) ? '0 : acc;
  assign acc_sum  = acc_base + prod_ext;

  // The first beat compares against the live th port, later beats against the captured copy.
  assign th_eff    = (state == IDLE) ? th : th_q;
  assign fire      = $signed(acc_sum) >= $signed(th_eff);
  assign last_beat = (state == IDLE) ? (N_INPUTS == 1)
                                     : (beat_cnt == CNT_W'(N_INPUTS - 1));

  // Ready drops during reset, while a result is pending, and whenever an abort is requested.
  assign in_ready  = rst_n && (state != DONE) && !clr;
  assign out_valid = (state == DONE);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort wins over everything, otherwise walk IDLE -> ACCUM -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, ACCUM: if (in_xfer) state_nxt = last_beat ? DONE : ACCUM;
        DONE:        if (out_ready) state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: accumulate on input beats, latch result on the last beat, clear on drain/abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      th_q     <= '0;
      beat_cnt <= '0;
      sum      <= '0;
      F        <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (in_xfer) begin
      acc      <= acc_sum;
      beat_cnt <= (state == IDLE) ? CNT_W'(1) : beat_cnt + CNT_W'(1);
      if (state == IDLE) th_q <= th;
      if (last_beat) begin
        sum <= acc_sum;
        F   <= fire;
      end
    end else if (out_xfer) begin
      acc      <= '0;
      beat_cnt <= '0;
    end
  end

endmodule
